wb_regfile: RTL

- Consumer end of the MEM/WB pipeline interface: the write-back stage fused with the 64-bit integer register file.
- Takes the MEM/WB register outputs and selects load data or ALU result as the write-back value.
- Commits that value to a 32x64 register file with x0 hardwired to zero.
- Serves two decode-stage read ports with same-cycle write-through bypass, and counts retired register writes.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/wb_load_ext.sv | 25 ++
 rtl/wb_regfile.sv | 83 ++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV64 constants for the write-back stage and register file.
// Load-width codes are used only when WB_LOAD_EXT_EN is defined.
package riscv_pkg;

    localparam int XLEN       = 64;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = 5;

    localparam int WB_REGWRITE_BIT = 1;
    localparam int WB_MEMTOREG_BIT = 0;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/wb_load_ext.sv
// Narrows raw load data to the access width and sign/zero extends it.
// Only instantiated when WB_LOAD_EXT_EN is defined.
module wb_load_ext
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] data_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        unique case (funct3_i)
            F3_LB:   data_o = {{(XLEN-8){data_i[7]}}, data_i[7:0]};
            F3_LH:   data_o = {{(XLEN-16){data_i[15]}}, data_i[15:0]};
            F3_LW:   data_o = {{(XLEN-32){data_i[31]}}, data_i[31:0]};
            F3_LD:   data_o = data_i;
            F3_LBU:  data_o = {{(XLEN-8){1'b0}}, data_i[7:0]};
            F3_LHU:  data_o = {{(XLEN-16){1'b0}}, data_i[15:0]};
            F3_LWU:  data_o = {{(XLEN-32){1'b0}}, data_i[31:0]};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage fused with the 32x64 register file (x0 = 0).
// Define WB_LOAD_EXT_EN to add ld_funct3 and in-stage load extension.
module wb_regfile
    import riscv_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
`ifdef WB_LOAD_EXT_EN
    input  logic [2:0]            ld_funct3,
`endif
    input  logic [XLEN-1:0]       DM_buffer_in,
    input  logic [XLEN-1:0]       aluResult_in,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic [1:0]            wbBuffer_in,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    output logic [XLEN-1:0]       wb_data,
    output logic                  wb_en,
    output logic [31:0]           wb_count
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [31:0]     count_q;
    logic [31:0]     count_d;
    logic [XLEN-1:0] load_data;

`ifdef WB_LOAD_EXT_EN
    wb_load_ext u_load_ext (
        .data_i   (DM_buffer_in),
        .funct3_i (ld_funct3),
        .data_o   (load_data)
    );
`else
    assign load_data = DM_buffer_in;
`endif

    assign wb_data = wbBuffer_in[WB_MEMTOREG_BIT] ? load_data
                                                  : aluResult_in;
    assign wb_en   = wbBuffer_in[WB_REGWRITE_BIT] && (rd_in != '0);

    assign count_d  = wb_en ? count_q + 32'd1 : count_q;
    assign wb_count = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            if (wb_en) begin
                regs_q[rd_in] <= wb_data;
            end
            count_q <= count_d;
        end
    end

    // Bypass lets decode see a write in the same cycle it commits.
    always_comb begin
        rs1_data = '0;
        if (rs1_addr != '0) begin
            if (wb_en && rs1_addr == rd_in) begin
                rs1_data = wb_data;
            end else begin
                rs1_data = regs_q[rs1_addr];
            end
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2_addr != '0) begin
            if (wb_en && rs2_addr == rd_in) begin
                rs2_data = wb_data;
            end else begin
                rs2_data = regs_q[rs2_addr];
            end
        end
    end

endmodule
